// File: rtl/crt_cookie_gen.sv
// rtl/crt_cookie_gen.sv - CRT status-path cookie injector: tick counter, timed
// MSB-first cookie window on test, noice pass-through otherwise.
module crt_cookie_gen #(
  parameter int                CNT_W     = 12,
  parameter logic [CNT_W-1:0]  TRIGGER   = 12'hB68,
  parameter int                COOKIE_W  = 8,
  parameter logic [COOKIE_W-1:0] COOKIE  = 8'hB2,
  parameter int                BIT_TICKS = 8,
  parameter bit                ONESHOT   = 1'b0,
  parameter int                SENT_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ena,
  input  logic                noice,
  input  logic                cookie_we,
  input  logic [COOKIE_W-1:0] cookie_din,
  input  logic                arm,
  output logic                test,
  output logic                busy,
  output logic                done,
  output logic [SENT_W-1:0]   sent_cnt
);

  localparam int IDX_W = (COOKIE_W > 1) ? $clog2(COOKIE_W) : 1;
  localparam int SUB_W = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(COOKIE_W - 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(BIT_TICKS - 1);

  if (COOKIE_W * BIT_TICKS > 2 ** CNT_W) begin : g_window_too_long
    $error("crt_cookie_gen: cookie window longer than counter frame");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [COOKIE_W-1:0] cookie_reg, cookie_nxt;
  logic [COOKIE_W-1:0] shift, shift_nxt;
  logic [IDX_W-1:0]    bit_idx, idx_nxt, cur_idx;
  logic [SUB_W-1:0]    sub, sub_nxt, cur_sub;
  logic                armed, armed_nxt;
  logic                test_nxt, done_nxt;
  logic [SENT_W-1:0]   sent_nxt;
  logic                trig, in_win, last, cur_bit;

  // The trigger tick is itself window tick 0, so it is resolved combinationally
  // from cookie_reg rather than waiting a tick for the shift register.
  always_comb begin
    trig    = ena && (state == IDLE) && (cnt == TRIGGER) && armed;
    in_win  = trig || (ena && (state == SEND));
    cur_idx = trig ? IDX_MSB : bit_idx;
    cur_sub = trig ? '0 : sub;
    cur_bit = trig ? cookie_reg[cur_idx] : shift[cur_idx];
    last    = in_win && (cur_idx == '0) && (cur_sub == SUB_LAST);

    state_nxt  = state;
    cnt_nxt    = ena ? cnt + 1'b1 : cnt;
    test_nxt   = test;
    idx_nxt    = bit_idx;
    sub_nxt    = sub;
    shift_nxt  = trig ? cookie_reg : shift;
    cookie_nxt = (cookie_we && (state == IDLE)) ? cookie_din : cookie_reg;
    done_nxt   = last;
    sent_nxt   = (last && (sent_cnt != '1)) ? sent_cnt + 1'b1 : sent_cnt;
    armed_nxt  = 1'b1;

    if (ena) test_nxt = in_win ? cur_bit : noice;

    if (in_win) begin
      state_nxt = last ? IDLE : SEND;
      if (cur_sub == SUB_LAST) begin
        sub_nxt = '0;
        idx_nxt = cur_idx - 1'b1;
      end else begin
        sub_nxt = cur_sub + 1'b1;
        idx_nxt = cur_idx;
      end
    end

    // A re-arm wins over the clear so an arm during the window is not lost.
    if (ONESHOT) begin
      if (arm)       armed_nxt = 1'b1;
      else if (trig) armed_nxt = 1'b0;
      else           armed_nxt = armed;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      test       <= 1'b0;
      done       <= 1'b0;
      sent_cnt   <= '0;
      cookie_reg <= COOKIE;
      shift      <= '0;
      bit_idx    <= '0;
      sub        <= '0;
      armed      <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      test       <= test_nxt;
      done       <= done_nxt;
      sent_cnt   <= sent_nxt;
      cookie_reg <= cookie_nxt;
      shift      <= shift_nxt;
      bit_idx    <= idx_nxt;
      sub        <= sub_nxt;
      armed      <= armed_nxt;
    end
  end

  assign busy = (state == SEND);

endmodule

// File: tb/tb_crt_cookie_gen.sv
// tb/tb_crt_cookie_gen.sv - directed self-checking bench for crt_cookie_gen.
module tb_crt_cookie_gen;

  localparam int WS = 'hB68;
  localparam int WE = 'hBA7;

  logic       clk = 1'b0;
  logic       reset, ena, noice, cookie_we, arm;
  logic [7:0] cookie_din;

  logic       test_d, busy_d, done_d;
  logic [7:0] sent_d;
  logic       test_o, busy_o, done_o;
  logic [7:0] sent_o;
  logic       test_s, busy_s, done_s;
  logic [1:0] sent_s;

  crt_cookie_gen dut (
    .clk(clk), .reset(reset), .ena(ena), .noice(noice), .cookie_we(cookie_we),
    .cookie_din(cookie_din), .arm(arm), .test(test_d), .busy(busy_d),
    .done(done_d), .sent_cnt(sent_d)
  );

  crt_cookie_gen #(.ONESHOT(1'b1)) dut_os (
    .clk(clk), .reset(reset), .ena(ena), .noice(noice), .cookie_we(cookie_we),
    .cookie_din(cookie_din), .arm(arm), .test(test_o), .busy(busy_o),
    .done(done_o), .sent_cnt(sent_o)
  );

  crt_cookie_gen #(.CNT_W(4), .TRIGGER(4'd2), .COOKIE_W(2), .COOKIE(2'b10),
                   .BIT_TICKS(1), .SENT_W(2)) dut_s (
    .clk(clk), .reset(reset), .ena(ena), .noice(noice), .cookie_we(cookie_we),
    .cookie_din(cookie_din[1:0]), .arm(arm), .test(test_s), .busy(busy_s),
    .done(done_s), .sent_cnt(sent_s)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_fail = 0;
  int         sel;
  logic       o_test, o_busy, o_done;
  logic [7:0] o_sent;

  always_comb begin
    o_test = (sel == 1) ? test_o : test_d;
    o_busy = (sel == 1) ? busy_o : busy_d;
    o_done = (sel == 1) ? done_o : done_d;
    o_sent = (sel == 1) ? sent_o : sent_d;
  end

  int          tick_n, we_at, arm_at;
  logic [7:0]  we_din;
  logic        rnd_noice;
  logic [63:0] win;
  int          out_bad, busy_bad, hold_bad, done_cnt, done_tick;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] expand(input logic [7:0] c);
    logic [63:0] e;
    e = '0;
    for (int i = 7; i >= 0; i--) e = {e[55:0], {8{c[i]}}};
    return e;
  endfunction

  task automatic reset_dut();
    ena = 0; noice = 0; cookie_we = 0; arm = 0; cookie_din = '0;
    reset = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0;
    tick_n = 0;
  endtask

  task automatic run_ticks(input int n, input int gap, input logic exp_send);
    for (int i = 0; i < n; i++) begin
      int   c;
      logic t_hold, b_hold;
      c = tick_n % 4096;
      ena = 1;
      noice = rnd_noice ? 1'($urandom) : 1'b1;
      cookie_we = (c == we_at);
      cookie_din = we_din;
      arm = (c == arm_at);
      @(posedge clk); #1;
      tick_n++;
      ena = 0; cookie_we = 0; arm = 0;
      if (o_done) begin done_cnt++; done_tick = c + 1; end
      if (exp_send && c >= WS && c <= WE) win = {win[62:0], o_test};
      else if (o_test !== noice) out_bad++;
      if (o_busy !== (exp_send && c >= WS && c < WE)) busy_bad++;
      t_hold = o_test; b_hold = o_busy;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        if (o_test !== t_hold || o_busy !== b_hold) hold_bad++;
        if (o_done) done_cnt++;
      end
    end
  endtask

  task automatic frame(input int gap, input logic exp_send);
    win = '0; out_bad = 0; busy_bad = 0; hold_bad = 0; done_cnt = 0; done_tick = -1;
    run_ticks(4096, gap, exp_send);
  endtask

  initial begin
    sel = 0; rnd_noice = 0; we_at = -1; arm_at = -1; we_din = '0;
    reset_dut();
    check("rst_test", test_d, 0);
    check("rst_busy", busy_d, 0);
    check("rst_done", done_d, 0);
    check("rst_sent", sent_d, 0);

    // defaults, noice=1
    frame(0, 1'b1);
    check("t1_win", win, expand(8'hB2));
    check("t1_outside", out_bad, 0);
    check("t1_busy", busy_bad, 0);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_done_tick", done_tick, 'hBA8);
    check("t1_sent", sent_d, 1);
    frame(0, 1'b1);
    check("t1_win2", win, expand(8'hB2));
    check("t1_sent2", sent_d, 2);

    // sparse ena, random noice
    rnd_noice = 1;
    frame(2, 1'b1);
    check("t2_win", win, expand(8'hB2));
    check("t2_outside", out_bad, 0);
    check("t2_busy", busy_bad, 0);
    check("t2_hold", hold_bad, 0);
    check("t2_done_cnt", done_cnt, 1);

    // cookie writes: IDLE, during SEND, same clk as trigger
    we_at = 'h10;  we_din = 8'h5A; frame(0, 1'b1);
    check("t3_win_5a", win, expand(8'h5A));
    we_at = 'hB80; we_din = 8'hFF; frame(0, 1'b1);
    check("t3_win_send_we", win, expand(8'h5A));
    we_at = WS;    we_din = 8'h33; frame(0, 1'b1);
    check("t3_win_trig_we", win, expand(8'h5A));
    we_at = -1;    frame(0, 1'b1);
    check("t3_win_33", win, expand(8'h33));
    check("t3_outside", out_bad, 0);
    check("t3_sent", sent_d, 7);

    // one-shot instance
    sel = 1;
    reset_dut();
    frame(0, 1'b1);
    check("t4_win1", win, expand(8'hB2));
    arm_at = 'hC00; frame(0, 1'b0);
    check("t4_f2_outside", out_bad, 0);
    check("t4_f2_busy", busy_bad, 0);
    check("t4_f2_done", done_cnt, 0);
    arm_at = -1; frame(0, 1'b1);
    check("t4_win3", win, expand(8'hB2));
    check("t4_sent", sent_o, 2);

    // asynchronous reset mid-window
    sel = 0;
    reset_dut();
    win = '0; out_bad = 0; busy_bad = 0; done_cnt = 0;
    run_ticks('hB81, 0, 1'b1);
    check("t5_pre_busy", busy_d, 1);
    check("t5_pre_test", test_d, 1);
    reset = 1; #2;
    check("t5_test", test_d, 0);
    check("t5_busy", busy_d, 0);
    check("t5_done", done_d, 0);
    check("t5_sent", sent_d, 0);
    @(posedge clk); #1;
    reset = 0; tick_n = 0;
    frame(0, 1'b1);
    check("t5_win", win, expand(8'hB2));
    check("t5_busy_win", busy_bad, 0);
    check("t5_sent_after", sent_d, 1);

    // small instance saturation
    reset_dut();
    for (int f = 1; f <= 4; f++) begin
      for (int c = 0; c < 16; c++) begin
        ena = 1; noice = 1;
        @(posedge clk); #1;
        ena = 0;
        if (f == 1 && c == 2) check("t6_bit1", test_s, 1);
        if (f == 1 && c == 3) begin
          check("t6_bit0", test_s, 0);
          check("t6_done", done_s, 1);
        end
      end
      check($sformatf("t6_sent_f%0d", f), sent_s, (f > 3) ? 3 : f);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
